// File: rtl/arm_pkg.sv
// Shared definitions for the ARM immediate-operand encoder.
// Field widths for {rotate_imm, imm8}, the encoder FSM states and the
// search phase (plain constant vs. its bitwise inverse for MVN).
package arm_pkg;

    localparam int ROT_W      = 4;
    localparam int IMM8_W     = 8;
    localparam int SHIFT_OP_W = ROT_W + IMM8_W;
    localparam int NUM_ROT    = 1 << ROT_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } imm_enc_state_t;

    typedef enum logic {
        PLAIN = 1'b0,
        INV   = 1'b1
    } phase_t;

endpackage

// File: rtl/imm_rot_check.sv
// Combinational check of one candidate rotation.
// Rotates cand left by 2*r; if the result fits in 8 bits then
// ROR(imm8, 2*r) == cand and {r, imm8} is a legal immediate field.
module imm_rot_check
    import arm_pkg::*;
(
    input  logic [31:0]       cand,
    input  logic [ROT_W-1:0]  r,
    output logic              match,
    output logic [IMM8_W-1:0] imm8
);

    logic [4:0]  sh;
    logic [5:0]  sh_back;
    logic [31:0] t;

    // A right shift by 32 yields zero, so r=0 is a plain identity.
    assign sh      = {r, 1'b0};
    assign sh_back = 6'd32 - {1'b0, sh};
    assign t       = (cand << sh) | (cand >> sh_back);

    assign match = ~|t[31:IMM8_W];
    assign imm8  = t[IMM8_W-1:0];

endmodule

// File: rtl/imm_operand_encoder.sv
// Encodes a 32-bit constant as the 12-bit data-processing immediate
// {rotate_imm, imm8}, preferring the plain value over its inverse and the
// smallest rotation, and reports the result over a start/done handshake.
// Optional build macro: IMM_ENC_PARALLEL_EN -- when defined, all 32
// candidates are checked in one cycle; otherwise one candidate per cycle.
module imm_operand_encoder
    import arm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           value,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic                  inv,
    output logic [SHIFT_OP_W-1:0] shift_operand
);

    imm_enc_state_t        state_q, state_d;
    logic [31:0]           value_q, value_d;
    logic                  valid_q, valid_d;
    logic                  inv_q, inv_d;
    logic [SHIFT_OP_W-1:0] shift_q, shift_d;

    // Search result for the current cycle and whether the candidate space
    // is exhausted once this cycle fails.
    logic                  srch_hit;
    logic                  srch_inv;
    logic [SHIFT_OP_W-1:0] srch_shift;
    logic                  srch_last;

    logic                  accept;

    assign accept = (state_q == IDLE) && start;

`ifdef IMM_ENC_PARALLEL_EN
    logic [2*NUM_ROT-1:0] par_match;
    logic [IMM8_W-1:0]    par_imm8 [2*NUM_ROT];

    // Candidate index k: bit 4 selects the inverse phase, bits 3:0 the
    // rotation, so ascending k is exactly the required priority order.
    for (genvar g = 0; g < 2 * NUM_ROT; g++) begin : g_cand
        imm_rot_check u_chk (
            .cand  ((g >= NUM_ROT) ? ~value_q : value_q),
            .r     (ROT_W'(g % NUM_ROT)),
            .match (par_match[g]),
            .imm8  (par_imm8[g])
        );
    end

    // Priority-encode: scan downwards so the lowest matching index wins.
    always_comb begin
        srch_hit   = 1'b0;
        srch_inv   = 1'b0;
        srch_shift = '0;
        for (int k = 2 * NUM_ROT - 1; k >= 0; k--) begin
            if (par_match[k]) begin
                srch_hit   = 1'b1;
                srch_inv   = k[ROT_W];
                srch_shift = {ROT_W'(k), par_imm8[k]};
            end
        end
    end

    assign srch_last = 1'b1;
`else
    logic [ROT_W-1:0]  r_q, r_d;
    phase_t            phase_q, phase_d;
    logic [31:0]       cand;
    logic              chk_match;
    logic [IMM8_W-1:0] chk_imm8;

    assign cand = (phase_q == INV) ? ~value_q : value_q;

    imm_rot_check u_chk (
        .cand  (cand),
        .r     (r_q),
        .match (chk_match),
        .imm8  (chk_imm8)
    );

    assign srch_hit   = chk_match;
    assign srch_inv   = (phase_q == INV);
    assign srch_shift = {r_q, chk_imm8};
    assign srch_last  = (r_q == ROT_W'(NUM_ROT - 1)) && (phase_q == INV);

    // Rotation/phase walker: r runs 0..15 in PLAIN, then again in INV.
    always_comb begin
        r_d     = r_q;
        phase_d = phase_q;
        if (accept) begin
            r_d     = '0;
            phase_d = PLAIN;
        end else if ((state_q == SEARCH) && !srch_hit) begin
            if (r_q != ROT_W'(NUM_ROT - 1)) begin
                r_d = r_q + ROT_W'(1);
            end else if (phase_q == PLAIN) begin
                r_d     = '0;
                phase_d = INV;
            end
        end
    end

    // Walker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            phase_q <= PLAIN;
        end else begin
            r_q     <= r_d;
            phase_q <= phase_d;
        end
    end
`endif

    // FSM next state and result updates.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        valid_d = valid_q;
        inv_d   = inv_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    value_d = value;
                    valid_d = 1'b0;
                    inv_d   = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (srch_hit) begin
                    valid_d = 1'b1;
                    inv_d   = srch_inv;
                    shift_d = srch_shift;
                    state_d = DONE;
                end else if (srch_last) begin
                    valid_d = 1'b0;
                    inv_d   = 1'b0;
                    shift_d = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers; reset aborts any search at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            inv_q   <= 1'b0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            inv_q   <= inv_d;
            shift_q <= shift_d;
        end
    end

    // Captured constant; only meaningful while busy, so no reset needed.
    always_ff @(posedge clk) begin
        value_q <= value_d;
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign valid         = valid_q;
    assign inv           = inv_q;
    assign shift_operand = shift_q;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Scoreboard bench for imm_operand_encoder: directed cases plus random
// constants; expected results come from a forward decode of every
// immediate field in priority order.
module tb_imm_operand_encoder;

    typedef struct {
        logic        vld;
        logic        inv;
        logic [11:0] sh;
        int          lat;
        int          e0;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic        inv;
    logic [11:0] shift_operand;

    int   checks;
    int   errors;
    int   cyc;
    exp_t sbq[$];

    imm_operand_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .value         (value),
        .busy          (busy),
        .done          (done),
        .valid         (valid),
        .inv           (inv),
        .shift_operand (shift_operand)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x >> n) | (x << (32 - n));
    endfunction

    // Forward model: walk every field in priority order (plain before
    // inverse, small rotation first) and decode it; first hit wins.
    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        logic [31:0] c;
        e.vld = 1'b0; e.inv = 1'b0; e.sh = 12'h000; e.lat = 32; e.e0 = 0; e.val = v;
        for (int ph = 0; ph < 2; ph++) begin
            c = (ph == 1) ? ~v : v;
            for (int r = 0; r < 16; r++) begin
                for (int i = 0; i < 256; i++) begin
                    if (ror32(32'(i), 2 * r) == c) begin
                        e.vld = 1'b1;
                        e.inv = (ph == 1);
                        e.sh  = {4'(r), 8'(i)};
                        e.lat = (ph == 1) ? 17 + r : r + 1;
                        return e;
                    end
                end
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] v, input logic vl, input logic iv,
                                input logic [11:0] s, input int lat);
        exp_t e;
        e.val = v; e.vld = vl; e.inv = iv; e.sh = s; e.lat = lat; e.e0 = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on each completion pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            logic [31:0] tgt;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = sbq.pop_front();
                chk("valid", 32'(valid), 32'(e.vld));
                chk("inv", 32'(inv), 32'(e.inv));
                chk("shift_operand", 32'(shift_operand), 32'(e.sh));
`ifdef IMM_ENC_PARALLEL_EN
                chk("latency", 32'(cyc - e.e0), 32'd1);
`else
                chk("latency", 32'(cyc - e.e0), 32'(e.lat));
`endif
                chk("busy_at_done", 32'(busy), 32'd1);
                if (valid) begin
                    tgt = inv ? ~e.val : e.val;
                    chk("decode", ror32({24'h0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8])), tgt);
                end
            end
        end
    end

    // Issue one request and wait (bounded) for its completion.
    task automatic issue(input logic [31:0] v, input exp_t e, input bit poke5, input bit poke_done);
        bit seen;
        seen = 0;
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.e0 = cyc;
        sbq.push_back(e);
        chk("busy_after_accept", 32'(busy), 32'd1);
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (poke5 && n == 5) begin
                value = 32'h000000FF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
                if (poke_done) begin
                    value = 32'h000000FF;
                    start = 1'b1;
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                chk("busy_after_done", 32'(busy), 32'd0);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in 40 cycles, expected done");
            sbq.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_inv"}, 32'(inv), 32'd0);
        chk({tag, "_shift"}, 32'(shift_operand), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        value  = 32'h0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases.
        issue(32'h000000FF, mk(32'h000000FF, 1, 0, 12'h0FF, 1), 0, 0);
        issue(32'hFF000000, mk(32'hFF000000, 1, 0, 12'h4FF, 5), 0, 0);
        issue(32'hF000000F, mk(32'hF000000F, 1, 0, 12'h2FF, 3), 0, 1);
        issue(32'h000003FC, mk(32'h000003FC, 1, 0, 12'hFFF, 16), 0, 0);
        issue(32'hFFFFFF00, mk(32'hFFFFFF00, 1, 1, 12'h0FF, 17), 0, 0);
        issue(32'h00000101, mk(32'h00000101, 0, 0, 12'h000, 32), 1, 0);
        issue(32'h00000000, mk(32'h00000000, 1, 0, 12'h000, 1), 0, 0);

        // Reset during a long search: aborts with no completion.
        @(negedge clk);
        value = 32'h00000101;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        issue(32'h00000000, mk(32'h00000000, 1, 0, 12'h000, 1), 0, 0);

        // Random constants: mix of encodable, inverted-encodable and arbitrary.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: v = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
                1: v = ~ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
                2: v = 32'($urandom_range(0, 1023));
                default: v = $urandom;
            endcase
            issue(v, model(v), 0, 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_operand_encoder.md
# imm_operand_encoder

Multi-cycle encoder that converts a 32-bit constant into the 12-bit data-processing immediate field `{rotate_imm[3:0], imm8[7:0]}`. The operand generator decodes this field as `ROR(imm8, 2*rotate_imm)`; this block performs the inverse. It sits beside the instruction-fetch/loader path and is used to synthesise `MOV` or `MVN` immediates. It searches for the smallest rotation that works, tries the bitwise inverse as a fallback for `MVN`, and reports the result over a start/done handshake.

## Interface
Parameters: none.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request pulse; sampled only in IDLE.
- `value`, input, 32: constant to encode; captured on the edge that accepts `start`.
- `busy`, output, 1: high from the accepting edge until `done` deasserts.
- `done`, output, 1: one-cycle completion pulse.
- `valid`, output, 1: an encoding was found. Held until the next accepted `start`.
- `inv`, output, 1: the encoding is for `~value` (use `MVN`). Held until the next accepted `start`.
- `shift_operand`, output, 12: `{rotate_imm, imm8}`. Held until the next accepted `start`.

## Operation
- States:
  - IDLE: `start` is accepted here. It latches `value`, sets `r=0` and `phase=PLAIN`, clears `valid`/`inv`, then goes to SEARCH.
  - SEARCH: each cycle computes `t = ROL(cand, 2*r)`, where `cand` is `value` when `phase=PLAIN` and `~value` when `phase=INV`. A match means `t[31:8]==0`.
    - On a match: register `shift_operand={r, t[7:0]}`, `valid=1`, `inv=(phase==INV)`, then go to DONE.
    - No match with `r<15`: increment `r`.
    - No match with `r==15` and `phase=PLAIN`: set `phase=INV` and `r=0`.
    - No match with `r==15` and `phase=INV`: go to DONE with `valid=0`, `inv=0` and `shift_operand=0`.
  - DONE: `done=1` for exactly one cycle, then go to IDLE.
- Priority: the PLAIN phase always beats INV, and a smaller `r` always beats a larger one. The output is therefore canonical.
- `value=0` encodes as `r=0`, `imm8=0`, `valid=1`, `inv=0`.
- `start` while `busy` is ignored and has no effect on the current search.
- `start` in the same cycle as `done` is ignored; `start` is accepted from the following IDLE cycle.
- Rotation arithmetic: 5-bit shift amount `{r,1'b0}`. `r=0` is the identity, with no wrap special case.
- Reset values: state=IDLE, `busy=0`, `done=0`, `valid=0`, `inv=0`, `shift_operand=0`, `r=0`, `phase=PLAIN`.
- Reset asserted mid-search: the operation is aborted immediately and asynchronously, and no `done` is produced.

## Timing
- E0 is the edge accepting `start`; `busy` is high from E0.
- Iterative mode, PLAIN match at rotation `r`: `done` is high in the cycle after edge E(r+1).
- Iterative mode, INV match at `r`: `done` follows E(17+r).
- Iterative mode, unencodable: `done` follows E32. This is the worst-case latency.
- `busy` falls on the edge where `done` falls (the DONE→IDLE edge).
- `valid`, `inv` and `shift_operand` are stable whenever `done=1` and stay stable until the next accepting edge.

## Configuration
- `IMM_ENC_PARALLEL_EN`
  - Defined: SEARCH evaluates all 32 candidates (16 rotations × 2 phases) in one cycle through a priority encoder using the same ordering. `done` always follows E1.
  - Undefined: one candidate per cycle, with the latencies given in Timing.
  - Results (`valid`, `inv`, `shift_operand`) are bit-identical in both modes.

## Structure
- Shared package `arm_pkg` holds:
  - `ROT_W=4` and `IMM8_W=8`.
  - The `imm_enc_state_t` enum {IDLE, SEARCH, DONE}.
  - A `phase_t` enum {PLAIN, INV}.
- Sub-module `imm_rot_check`: combinational. Inputs `cand[31:0]` and `r[3:0]`; outputs `match` and `imm8[7:0]`.
  - Instantiated once in iterative mode.
  - Instantiated 32 times in a generate loop in parallel mode.

## Test plan
- `value=0x000000FF` → `valid=1`, `inv=0`, `shift_operand=0x0FF`; `done` after E1 (iterative).
- `value=0xFF000000` → `shift_operand=0x4FF` (r=4); `value=0xF000000F` → `shift_operand=0x2FF`; `value=0x000003FC` → `shift_operand=0xFFF` (r=15, `done` after E16).
- `value=0xFFFFFF00` → `valid=1`, `inv=1`, `shift_operand=0x0FF`; `done` after E17 (iterative) or E1 (parallel).
- `value=0x00000101` → `valid=0`, `inv=0`, `shift_operand=0`; `done` after E32.
  - A second `start` pulsed at E5 is ignored: the result is unchanged and only one `done` occurs.
- `rst_n` dropped at E8 of a search → all outputs 0 immediately and no `done`.
  - A new `start` (`value=0`) after release → `valid=1`, `shift_operand=0`.
- Randomised constants (both modes, scoreboard): for every `valid` result, check `ROR(imm8, 2*r)` equals `value` (or `~value` when `inv=1`). Also check that no smaller `r`, or a PLAIN result when `inv=1`, would have matched.
